btb_ctrl: RTL and testbench
===========================

# btb_ctrl

Branch target buffer controller feeding the BTB storage: takes fetch-stage lookups and execute-stage branch resolutions, maintains per-entry valid/tag/target/2-bit counter state, and returns a registered next-PC prediction one cycle after each lookup. The block sits between the fetch PC generator and the execute stage. It owns the read-modify-write update pipeline, same-index bypass, and a sequential flush sweep.

## Interface
- width, 32, PC and target width
- bit_entry, 5, index bits; num_entry = 2**bit_entry direct-mapped entries
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, asynchronous, active-low
- fetch_valid  input  1  lookup request this cycle
- fetch_pc  input  width  lookup PC
- pred_valid  output  1  registered fetch_valid
- pred_hit  output  1  lookup hit a valid entry with matching tag
- pred_taken  output  1  pred_hit and counter MSB set
- pred_target  output  width  predicted next PC
- upd_valid  input  1  branch resolved this cycle
- upd_pc  input  width  PC of resolved branch
- upd_taken  input  1  actual direction
- upd_target  input  width  actual taken target
- flush  input  1  one-cycle pulse, invalidate all entries
- busy  output  1  flush sweep in progress

## Operation
- index = pc[bit_entry+1:2]; tag = pc[width-1:bit_entry+2]; pc[1:0] ignored.
- Entry = valid, tag, target, ctr[1:0].
- Lookup: hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = btb target if pred_taken, else fetch_pc + 4 (mod 2^width, 32'hFFFF_FFFC wraps to 0).
- Update, staged one cycle then read-modify-write:
  - hit, taken: ctr saturating +1 (max 3), target <= upd_target.
  - hit, not taken: ctr saturating −1 (min 0), target unchanged.
  - miss, taken: allocate/replace: valid=1, new tag, target, ctr=2.
  - miss, not taken: no change.
- Bypass: a lookup reading the index currently staged sees the post-update entry.
- FSM IDLE/FLUSH. IDLE + flush -> FLUSH, sweep counter = 0. FLUSH: clear valid[sweep] each cycle, increment. Leave after clearing num_entry−1 -> IDLE. busy = (state == FLUSH).
- During FLUSH: lookups answer pred_hit=0, pred_target=pc+4. upd_valid dropped. flush ignored.
- flush in IDLE also drops any update staged that cycle and any upd_valid in the same cycle.
- Flush clears valid only; tag/target/ctr retained but unobservable.

## Timing
- Reset (rst low, async): all valid=0, ctr=0, targets=0, state IDLE, sweep=0, staged update cleared. pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0, busy=0.
- Reset mid-flush: immediately IDLE, busy=0, all valid cleared.
- Lookup at cycle t -> pred_* valid in cycle t+1. Outputs are registered and hold when fetch_valid=0, but pred_valid=0.
- Update at t: staged at edge ending t, array written at edge ending t+1.
- Lookups at ≥ t+1 see it: at t+1 via bypass, at ≥ t+2 via array. A lookup at t sees the old entry.
- Back-to-back updates to the same index compose correctly, e.g. two taken updates on ctr=1 -> 3.
- flush at t: busy=1 in t+1 … t+num_entry, busy=0 at t+num_entry+1. First non-forced lookup is at t+num_entry+1.

## Test plan
- Reset then lookup 0x0000_0100 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x0000_0104.
- Update pc=0x100 taken target=0x400 at t; lookup 0x100 at t -> miss. Lookup at t+1 -> hit, taken, 0x400 (bypass). Lookup at t+5 -> same.
- Counter walk on 0x100, starting ctr=2: not-taken x1 -> predict not taken, target 0x104. Not-taken x2 more -> ctr=0 and stays. Taken x2 -> predict taken.
- Alias: allocate 0x100 (taken), then update 0x1100 taken target 0x800 -> lookup 0x100 misses, lookup 0x1100 hits with 0x800.
- Flush with bit_entry=5 after filling 4 entries: busy high exactly 32 cycles. Lookups and update during sweep give hit=0 and cause no allocation. After sweep, all 4 miss.
- Assert rst low on flush sweep cycle 10 -> busy=0 and all outputs 0 immediately. After release, lookups miss.

Source files
------------

// File: rtl/btb_ctrl.sv
// Branch target buffer controller.
// Direct-mapped BTB with registered next-PC prediction, a one-cycle staged
// read-modify-write update path with same-index bypass, and a sequential
// flush sweep that clears one valid bit per cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   fetch_valid, fetch_pc         lookup request
//   pred_valid/hit/taken/target   registered prediction, one cycle after lookup
//   upd_valid/pc/taken/target     execute-stage branch resolution
//   flush                         one-cycle pulse, invalidate all entries
//   busy                          flush sweep in progress
module btb_ctrl #(
    parameter int unsigned width     = 32,
    parameter int unsigned bit_entry = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [width-1:0] fetch_pc,
    output logic             pred_valid,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [width-1:0] pred_target,
    input  logic             upd_valid,
    input  logic [width-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [width-1:0] upd_target,
    input  logic             flush,
    output logic             busy
);

    localparam int unsigned num_entry = 1 << bit_entry;
    localparam int unsigned tag_w     = width - bit_entry - 2;
    localparam logic [bit_entry-1:0] last_idx = bit_entry'(num_entry - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic [bit_entry-1:0] sweep_q, sweep_d;

    // Entry storage
    logic [num_entry-1:0] valid_q;
    logic [tag_w-1:0]     tag_q [num_entry];
    logic [width-1:0]     tgt_q [num_entry];
    logic [1:0]           ctr_q [num_entry];

    // Staged update
    logic                 stg_valid_q;
    logic [bit_entry-1:0] stg_idx_q;
    logic [tag_w-1:0]     stg_tag_q;
    logic                 stg_taken_q;
    logic [width-1:0]     stg_target_q;

    // Low PC bits carry no information for a word-aligned BTB
    logic unused_pc_bits;
    assign unused_pc_bits = ^upd_pc[1:0];

    logic idle, accept_upd, commit;
    assign idle       = (state_q == S_IDLE);
    assign accept_upd = idle && !flush && upd_valid;
    // A flush in IDLE drops whatever update is staged this cycle
    assign commit     = idle && !flush && stg_valid_q;

    // Next-state and sweep counter
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    sweep_d = '0;
                end
            end
            S_FLUSH: begin
                sweep_d = sweep_q + bit_entry'(1);
                if (sweep_q == last_idx) begin
                    state_d = S_IDLE;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            busy    <= (state_d == S_FLUSH);
        end
    end

    // Post-update entry for the staged index (read-modify-write)
    logic             old_hit, new_wr, new_valid;
    logic [tag_w-1:0] new_tag;
    logic [width-1:0] new_tgt;
    logic [1:0]       new_ctr;

    always_comb begin
        old_hit   = valid_q[stg_idx_q] && (tag_q[stg_idx_q] == stg_tag_q);
        new_wr    = 1'b0;
        new_valid = valid_q[stg_idx_q];
        new_tag   = tag_q[stg_idx_q];
        new_tgt   = tgt_q[stg_idx_q];
        new_ctr   = ctr_q[stg_idx_q];
        if (old_hit) begin
            new_wr = 1'b1;
            if (stg_taken_q) begin
                new_ctr = (ctr_q[stg_idx_q] == 2'd3) ? 2'd3 : ctr_q[stg_idx_q] + 2'd1;
                new_tgt = stg_target_q;
            end else begin
                new_ctr = (ctr_q[stg_idx_q] == 2'd0) ? 2'd0 : ctr_q[stg_idx_q] - 2'd1;
            end
        end else if (stg_taken_q) begin
            new_wr    = 1'b1;
            new_valid = 1'b1;
            new_tag   = stg_tag_q;
            new_tgt   = stg_target_q;
            new_ctr   = 2'd2;
        end
    end

    // Lookup with bypass of the staged entry
    logic [bit_entry-1:0] f_idx;
    logic [tag_w-1:0]     f_tag;
    logic                 l_valid;
    logic [tag_w-1:0]     l_tag;
    logic [width-1:0]     l_tgt;
    logic [1:0]           l_ctr;
    logic                 look_hit, look_taken;
    logic [width-1:0]     look_target;

    always_comb begin
        f_idx = fetch_pc[bit_entry+1:2];
        f_tag = fetch_pc[width-1:bit_entry+2];
        if (commit && (stg_idx_q == f_idx)) begin
            l_valid = new_valid;
            l_tag   = new_tag;
            l_tgt   = new_tgt;
            l_ctr   = new_ctr;
        end else begin
            l_valid = valid_q[f_idx];
            l_tag   = tag_q[f_idx];
            l_tgt   = tgt_q[f_idx];
            l_ctr   = ctr_q[f_idx];
        end
        look_hit    = idle && l_valid && (l_tag == f_tag);
        look_taken  = look_hit && l_ctr[1];
        look_target = look_taken ? l_tgt : fetch_pc + width'(4);
    end

    // Prediction registers; hold when no lookup
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_valid <= fetch_valid;
            if (fetch_valid) begin
                pred_hit    <= look_hit;
                pred_taken  <= look_taken;
                pred_target <= look_target;
            end
        end
    end

    // Update staging register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_valid_q  <= 1'b0;
            stg_idx_q    <= '0;
            stg_tag_q    <= '0;
            stg_taken_q  <= 1'b0;
            stg_target_q <= '0;
        end else begin
            stg_valid_q <= accept_upd;
            if (accept_upd) begin
                stg_idx_q    <= upd_pc[bit_entry+1:2];
                stg_tag_q    <= upd_pc[width-1:bit_entry+2];
                stg_taken_q  <= upd_taken;
                stg_target_q <= upd_target;
            end
        end
    end

    // Entry array: sweep clear or staged write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(num_entry); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (state_q == S_FLUSH) begin
            valid_q[sweep_q] <= 1'b0;
        end else if (commit && new_wr) begin
            valid_q[stg_idx_q] <= new_valid;
            tag_q[stg_idx_q]   <= new_tag;
            tgt_q[stg_idx_q]   <= new_tgt;
            ctr_q[stg_idx_q]   <= new_ctr;
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed scenarios plus random traffic,
// predictions checked by a scoreboard fed from a behavioural model.
module tb_btb_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned BE = 5;
    localparam int unsigned NE = 32;

    logic          clk;
    logic          rst;
    logic          fetch_valid;
    logic [W-1:0]  fetch_pc;
    logic          pred_valid;
    logic          pred_hit;
    logic          pred_taken;
    logic [W-1:0]  pred_target;
    logic          upd_valid;
    logic [W-1:0]  upd_pc;
    logic          upd_taken;
    logic [W-1:0]  upd_target;
    logic          flush;
    logic          busy;

    btb_ctrl #(.width(W), .bit_entry(BE)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pred_valid  (pred_valid),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         hit;
        logic         taken;
        logic [W-1:0] target;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state
    bit           m_valid [NE];
    int unsigned  m_tag   [NE];
    logic [W-1:0] m_tgt   [NE];
    int           m_ctr   [NE];
    bit           p_v;
    logic [W-1:0] p_pc;
    bit           p_taken;
    logic [W-1:0] p_tgt;
    int           m_busy;

    function automatic int unsigned f_idx(logic [W-1:0] pc);
        return (pc / 4) % NE;
    endfunction

    function automatic int unsigned f_tag(logic [W-1:0] pc);
        return pc / (4 * NE);
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(NE); i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        p_v    = 0;
        m_busy = 0;
        q.delete();
    endtask

    task automatic m_apply(logic [W-1:0] pc, bit taken, logic [W-1:0] tgt);
        int unsigned i;
        i = f_idx(pc);
        if (m_valid[i] && m_tag[i] == f_tag(pc)) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1;
            m_tag[i]   = f_tag(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endtask

    // One clock cycle: model, scoreboard push, drive, then busy check
    task automatic step(bit fv, logic [W-1:0] fpc, bit uv, logic [W-1:0] upc,
                        bit ut, logic [W-1:0] utgt, bit fl);
        bit           idle;
        exp_t         e;
        int unsigned  i;
        idle = (m_busy == 0);
        // An update becomes visible the cycle after it is presented
        if (p_v && !(idle && fl)) m_apply(p_pc, p_taken, p_tgt);
        p_v = 0;
        if (fv) begin
            i = f_idx(fpc);
            e.hit    = idle && m_valid[i] && (m_tag[i] == f_tag(fpc));
            e.taken  = e.hit && (m_ctr[i] >= 2);
            e.target = e.taken ? m_tgt[i] : fpc + 32'd4;
            q.push_back(e);
        end
        if (!idle) begin
            m_busy--;
        end else if (fl) begin
            for (int k = 0; k < int'(NE); k++) m_valid[k] = 0;
            m_busy = NE;
        end else if (uv) begin
            p_v = 1; p_pc = upc; p_taken = ut; p_tgt = utgt;
        end
        fetch_valid = fv; fetch_pc = fpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        flush = fl;
        @(posedge clk);
        #1;
        check("busy", 32'(busy), 32'(m_busy != 0));
    endtask

    task automatic look(logic [W-1:0] pc);
        step(1, pc, 0, '0, 0, '0, 0);
    endtask

    task automatic upd(logic [W-1:0] pc, bit t, logic [W-1:0] tgt);
        step(0, '0, 1, pc, t, tgt, 0);
    endtask

    task automatic idle_cyc();
        step(0, '0, 0, '0, 0, '0, 0);
    endtask

    // Monitor: every presented prediction must match the oldest expectation
    always @(negedge clk) begin
        if (rst && pred_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pred actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pred_hit", 32'(pred_hit), 32'(e.hit));
                check("pred_taken", 32'(pred_taken), 32'(e.taken));
                check("pred_target", pred_target, e.target);
            end
        end
    end

    task automatic check_outputs_zero(string tag);
        check({tag, "_pred_valid"}, 32'(pred_valid), 32'd0);
        check({tag, "_pred_hit"}, 32'(pred_hit), 32'd0);
        check({tag, "_pred_taken"}, 32'(pred_taken), 32'd0);
        check({tag, "_pred_target"}, pred_target, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] pc, tgt;
        rst = 1'b0;
        fetch_valid = 0; fetch_pc = '0;
        upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
        flush = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Lookup after reset misses
        look(32'h0000_0100);
        // Update and same-cycle lookup sees old entry, next cycle via bypass
        step(1, 32'h100, 1, 32'h100, 1, 32'h400, 0);
        look(32'h100);
        repeat (3) idle_cyc();
        look(32'h100);
        // Counter walk from 2
        upd(32'h100, 0, '0);
        look(32'h100);
        upd(32'h100, 0, '0);
        upd(32'h100, 0, '0);
        look(32'h100);
        upd(32'h100, 0, '0);
        look(32'h100);
        upd(32'h100, 1, 32'h444);
        upd(32'h100, 1, 32'h448);
        look(32'h100);
        // Alias on the same index
        upd(32'h1100, 1, 32'h800);
        idle_cyc();
        look(32'h100);
        look(32'h1100);
        // Fall-through wrap
        look(32'hFFFF_FFFC);

        // Fill four entries, flush, traffic during sweep, all miss after
        for (int k = 0; k < 4; k++) upd(32'h200 + 32'(4 * k), 1, 32'h900 + 32'(16 * k));
        idle_cyc();
        look(32'h204);
        step(1, 32'h208, 0, '0, 0, '0, 1);
        for (int k = 0; k < int'(NE); k++) begin
            if (k == 3) step(1, 32'h200, 1, 32'h300, 1, 32'hA00, 0);
            else if (k == 7) step(1, 32'h300, 0, '0, 0, '0, 1);
            else step(1, 32'h20C, 0, '0, 0, '0, 0);
        end
        for (int k = 0; k < 4; k++) look(32'h200 + 32'(4 * k));
        look(32'h300);

        // Reset during the sweep
        upd(32'h180, 1, 32'hB00);
        idle_cyc();
        step(1, 32'h180, 0, '0, 0, '0, 1);
        for (int k = 0; k < 10; k++) look(32'h180);
        fetch_valid = 0; upd_valid = 0; flush = 0;
        rst = 1'b0;
        m_reset();
        #1;
        check_outputs_zero("mid_flush_reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        look(32'h180);
        look(32'h100);

        // Random traffic on a small set of aliasing PCs
        for (int n = 0; n < 600; n++) begin
            bit fv, uv, ut, fl;
            fv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 1) != 0);
            ut  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 79) == 0);
            pc  = (32'($urandom_range(0, 2)) << (BE + 2)) | (32'($urandom_range(0, 3)) << 2)
                  | 32'($urandom_range(0, 3));
            tgt = $urandom & 32'hFFFF_FFFC;
            step(fv, pc, uv, (32'($urandom_range(0, 2)) << (BE + 2))
                 | (32'($urandom_range(0, 3)) << 2), ut, tgt, fl);
        end
        repeat (3) idle_cyc();
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
